// File: rtl/kn_rd_pkg.sv
// kn_rd_pkg: shared types and constants for the kn_rd "Knight Rider" LED scanner.
// Holds the scan state encoding and the bit positions of the fields in the
// control register (slv_reg0) that feed the scanner's run/wrap_mode inputs.
package kn_rd_pkg;

    typedef enum logic [1:0] {
        KN_IDLE      = 2'd0,
        KN_SCAN_UP   = 2'd1,
        KN_SCAN_DOWN = 2'd2
    } kn_state_t;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_WRAP = 1;

endpackage

// File: rtl/kn_rd_scanner_if.sv
// kn_rd_scanner_if: groups the register-side controls (run, wrap_mode, div)
// and the LED-side results (led_out, busy, step_pulse, sweep_pulse) of the
// scanner. The register file / bench drives through the master modport and
// the scanner implements the slave modport.
interface kn_rd_scanner_if #(
    parameter int C_LED_NUM   = 8,
    parameter int C_DIV_WIDTH = 32
);

    logic                   run;
    logic                   wrap_mode;
    logic [C_DIV_WIDTH-1:0] div;
    logic [C_LED_NUM-1:0]   led_out;
    logic                   busy;
    logic                   step_pulse;
    logic                   sweep_pulse;

    modport master (
        output run,
        output wrap_mode,
        output div,
        input  led_out,
        input  busy,
        input  step_pulse,
        input  sweep_pulse
    );

    modport slave (
        input  run,
        input  wrap_mode,
        input  div,
        output led_out,
        output busy,
        output step_pulse,
        output sweep_pulse
    );

endinterface

// File: rtl/kn_rd_prescaler.sv
// kn_rd_prescaler: step-rate divider for the scanner. Counts ACLK cycles while
// the scanner is active and raises tick once the count has reached div, so a
// step happens every div+1 cycles. Using >= rather than == lets a smaller div
// written mid-count take effect on the very next cycle instead of waiting for
// the counter to wrap all the way around.
module kn_rd_prescaler #(
    parameter int C_DIV_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [C_DIV_WIDTH-1:0] div,
    output logic                   tick
);

    logic [C_DIV_WIDTH-1:0] cnt;

    assign tick = !clear && (cnt >= div);

    // Count every active cycle; restart from zero on a tick or while held clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + C_DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/kn_rd_scanner.sv
// kn_rd_scanner: sequencing core of the kn_rd IP. Turns run/wrap_mode/div from
// the register file into the bouncing or wrapping one-hot LED scan, with
// registered led_out/busy/step_pulse/sweep_pulse.
// Optional feature: define KN_RD_TRAIL_EN to keep the previous position lit as
// a trail (two LEDs on after the first step). Without it only one LED is lit.
module kn_rd_scanner
    import kn_rd_pkg::*;
#(
    parameter int C_LED_NUM   = 8,
    parameter int C_DIV_WIDTH = 32
) (
    input  logic ACLK,
    input  logic ARESETN,
    kn_rd_scanner_if.slave bus
);

    localparam int               POS_W   = (C_LED_NUM > 1) ? $clog2(C_LED_NUM) : 1;
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [POS_W-1:0] LAST    = POS_W'(C_LED_NUM - 1);

    kn_state_t              state;
    kn_state_t              state_nxt;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       pos_nxt;
    logic                   tick;
    logic                   prescale_clear;
    logic                   step_nxt;
    logic                   sweep_nxt;
    logic [C_LED_NUM-1:0]   led_nxt;
    logic [C_LED_NUM-1:0]   led_q;
    logic                   busy_q;
    logic                   step_q;
    logic                   sweep_q;

    // The prescaler idles at zero whenever the scanner is idle or about to be
    assign prescale_clear = (state == KN_IDLE) || !bus.run;

    kn_rd_prescaler #(
        .C_DIV_WIDTH (C_DIV_WIDTH)
    ) u_prescaler (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .clear (prescale_clear),
        .div   (bus.div),
        .tick  (tick)
    );

    // Next state and position: start on run, abort on !run, otherwise move one place per tick
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        step_nxt  = 1'b0;
        sweep_nxt = 1'b0;
        case (state)
            KN_IDLE: begin
                if (bus.run) begin
                    state_nxt = KN_SCAN_UP;
                    pos_nxt   = '0;
                end
            end
            KN_SCAN_UP, KN_SCAN_DOWN: begin
                if (!bus.run) begin
                    state_nxt = KN_IDLE;
                    pos_nxt   = '0;
                end else if (tick) begin
                    step_nxt = 1'b1;
                    if (C_LED_NUM == 1) begin
                        pos_nxt   = '0;
                        sweep_nxt = 1'b1;
                    end else if (bus.wrap_mode) begin
                        if (state == KN_SCAN_DOWN) begin
                            state_nxt = KN_SCAN_UP;
                            pos_nxt   = pos + POS_ONE;
                        end else if (pos == LAST) begin
                            pos_nxt   = '0;
                            sweep_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + POS_ONE;
                        end
                    end else if (state == KN_SCAN_UP) begin
                        if (pos == LAST) begin
                            state_nxt = KN_SCAN_DOWN;
                            pos_nxt   = LAST - POS_ONE;
                        end else begin
                            pos_nxt = pos + POS_ONE;
                        end
                    end else begin
                        if (pos == '0) begin
                            state_nxt = KN_SCAN_UP;
                            pos_nxt   = POS_ONE;
                            sweep_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos - POS_ONE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = KN_IDLE;
                pos_nxt   = '0;
            end
        endcase
    end

`ifdef KN_RD_TRAIL_EN
    logic [POS_W-1:0] prev_pos;
    logic [POS_W-1:0] prev_nxt;

    // The trail follows the position being left: seeded on start, updated on each step
    always_comb begin
        prev_nxt = prev_pos;
        if (state == KN_IDLE || step_nxt) begin
            prev_nxt = pos;
        end
    end

    // Trail register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            prev_pos <= '0;
        end else begin
            prev_pos <= prev_nxt;
        end
    end

    // LED pattern: current position plus the trailing position while scanning
    always_comb begin
        led_nxt = '0;
        if (state_nxt != KN_IDLE) begin
            for (int i = 0; i < C_LED_NUM; i++) begin
                led_nxt[i] = (pos_nxt == POS_W'(i)) || (prev_nxt == POS_W'(i));
            end
        end
    end
`else
    // LED pattern: a single lit LED at the current position while scanning
    always_comb begin
        led_nxt = '0;
        if (state_nxt != KN_IDLE) begin
            for (int i = 0; i < C_LED_NUM; i++) begin
                led_nxt[i] = (pos_nxt == POS_W'(i));
            end
        end
    end
`endif

    // State, position and all outputs are registered so the LED pins never glitch
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= KN_IDLE;
            pos     <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            sweep_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pos     <= pos_nxt;
            led_q   <= led_nxt;
            busy_q  <= (state_nxt != KN_IDLE);
            step_q  <= step_nxt;
            sweep_q <= sweep_nxt;
        end
    end

    assign bus.led_out     = led_q;
    assign bus.busy        = busy_q;
    assign bus.step_pulse  = step_q;
    assign bus.sweep_pulse = sweep_q;

endmodule
